// File: rtl/vid_pkg.sv
// Shared types, widths and pixel helpers for the Slipstream video serializer.
package vid_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned PAL_W    = 8;
  localparam int unsigned BANK_W   = 4;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned PPW_8BPP = 2;
  localparam int unsigned PPW_4BPP = 4;

  typedef enum logic {
    MODE_8BPP = 1'b0,
    MODE_4BPP = 1'b1
  } pix_mode_t;

  typedef logic [PAL_W-1:0] pal_idx_t;

  // Pixels remaining in the shifter after the head pixel of a word is consumed.
  function automatic logic [CNT_W-1:0] ppw_minus1(input pix_mode_t m);
    return (m == MODE_4BPP) ? CNT_W'(PPW_4BPP - 1) : CNT_W'(PPW_8BPP - 1);
  endfunction

  // Palette index of the most significant pixel of a word.
  function automatic pal_idx_t head_pixel(input pix_mode_t m,
                                          input logic [BANK_W-1:0] bank,
                                          input logic [WORD_W-1:0] w);
    return (m == MODE_4BPP) ? {bank, w[15:12]} : w[15:8];
  endfunction

  // Word with its most significant pixel removed, remaining pixels left-aligned.
  function automatic logic [WORD_W-1:0] shift_pixel(input pix_mode_t m,
                                                    input logic [WORD_W-1:0] w);
    return (m == MODE_4BPP) ? {w[11:0], 4'h0} : {w[7:0], 8'h00};
  endfunction

endpackage

// File: rtl/vid_word_fifo.sv
// Small synchronous word FIFO with flush; a push in the flush cycle is kept.
module vid_word_fifo
  import vid_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_next_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d, wr_addr;
  logic [OCC_W-1:0]  cnt_q, cnt_d;
  logic              full, pop_ok, push_ok, we;

  assign full    = (cnt_q == OCC_W'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  // Pointer/occupancy update; a pop frees the slot for a push while full.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pop_ok  = pop_i && !empty_o && !flush_i;
    push_ok = push_i && (!full || pop_ok);
    we      = push_ok;
    wr_addr = wr_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = PTR_W'(push_i);
      cnt_d   = OCC_W'(push_i);
      we      = push_i;
      wr_addr = '0;
    end else begin
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      cnt_d = cnt_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end
    full_next_o = (cnt_d == OCC_W'(FIFO_DEPTH));
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= data_i;
  end

endmodule

// File: rtl/vid_pixel_serializer.sv
// Turns fetched video words into per-pixel palette addresses with border fill.
module vid_pixel_serializer
  import vid_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_ce,
  input  logic              line_start,
  input  logic              active,
  input  logic              mode,
  input  logic [BANK_W-1:0] pal_bank,
  input  logic [PAL_W-1:0]  border,
  output logic              word_req,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic [PAL_W-1:0]  pal_addr,
  output logic              underflow,
  input  logic              underflow_clr
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_en_q, fetch_en_d;
  logic              act_prev_q, act_prev_d;
  pix_mode_t         mode_q, mode_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  pal_idx_t          pal_q, pal_d;
  logic              uf_q, uf_d;
  logic              req_q, req_d;
  logic              uf_set;

  logic              fifo_pop, fifo_empty, fifo_full_next;
  logic [WORD_W-1:0] fifo_data;

  vid_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (line_start),
    .push_i      (word_valid),
    .pop_i       (fifo_pop),
    .data_i      (word_data),
    .data_o      (fifo_data),
    .empty_o     (fifo_empty),
    .full_next_o (fifo_full_next)
  );

  // Line control, pixel stepping and flag updates.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    fetch_en_d = fetch_en_q;
    act_prev_d = act_prev_q;
    mode_d     = mode_q;
    bank_d     = bank_q;
    pal_d      = pal_q;
    uf_set     = 1'b0;
    fifo_pop   = 1'b0;

    if (line_start) begin
      cnt_d      = '0;
      mode_d     = pix_mode_t'(mode);
      bank_d     = pal_bank;
      fetch_en_d = 1'b1;
      if (pix_ce) pal_d = border;
    end else begin
      if (pix_ce && act_prev_q && !active) fetch_en_d = 1'b0;
      if (pix_ce && active) begin
        if (cnt_q != '0) begin
          pal_d   = head_pixel(mode_q, bank_q, shift_q);
          shift_d = shift_pixel(mode_q, shift_q);
          cnt_d   = cnt_q - CNT_W'(1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pal_d    = head_pixel(mode_q, bank_q, fifo_data);
          shift_d  = shift_pixel(mode_q, fifo_data);
          cnt_d    = ppw_minus1(mode_q);
        end else begin
          pal_d  = border;
          uf_set = 1'b1;
        end
      end else if (pix_ce) begin
        pal_d = border;
      end
    end

    if (pix_ce) act_prev_d = active;
    uf_d  = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : uf_q);
    req_d = fetch_en_d && !fifo_full_next;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      fetch_en_q <= 1'b0;
      act_prev_q <= 1'b0;
      mode_q     <= MODE_8BPP;
      bank_q     <= '0;
      pal_q      <= '0;
      uf_q       <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      fetch_en_q <= fetch_en_d;
      act_prev_q <= act_prev_d;
      mode_q     <= mode_d;
      bank_q     <= bank_d;
      pal_q      <= pal_d;
      uf_q       <= uf_d;
      req_q      <= req_d;
    end
  end

  assign pal_addr  = pal_q;
  assign underflow = uf_q;
  assign word_req  = req_q;

endmodule

// File: tb/tb_vid_pixel_serializer.sv
// Directed and random checks of vid_pixel_serializer against a queue-based model.
module tb_vid_pixel_serializer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_ce, line_start, active, mode, word_valid, underflow_clr;
  logic [3:0]  pal_bank;
  logic [7:0]  border;
  logic [15:0] word_data;
  logic        word_req, underflow;
  logic [7:0]  pal_addr;

  int errors = 0;
  int checks = 0;

  // Reference model state: queued words, pending pixels of the current word.
  logic [15:0] fq[$];
  logic [7:0]  pq[$];
  logic        m_mode, m_fe, m_actp, m_uf, m_req;
  logic [3:0]  m_bank;
  logic [7:0]  m_pal;
  logic        r_act;

  vid_pixel_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pix_ce        (pix_ce),
    .line_start    (line_start),
    .active        (active),
    .mode          (mode),
    .pal_bank      (pal_bank),
    .border        (border),
    .word_req      (word_req),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .pal_addr      (pal_addr),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    pq.delete();
    m_mode = 1'b0; m_bank = 4'h0; m_fe = 1'b0; m_actp = 1'b0;
    m_uf = 1'b0; m_pal = 8'h00; m_req = 1'b0;
  endtask

  // One clock of behaviour computed from the current (sampled) inputs.
  task automatic model_update();
    int          sz;
    bit          popped, uf_set;
    logic [15:0] w;
    popped = 0;
    uf_set = 0;
    if (line_start) begin
      fq.delete();
      pq.delete();
      m_mode = mode;
      m_bank = pal_bank;
      m_fe   = 1'b1;
      if (pix_ce) m_pal = border;
      if (word_valid) fq.push_back(word_data);
    end else begin
      sz = fq.size();
      if (pix_ce && active) begin
        if (pq.size() > 0) begin
          m_pal = pq.pop_front();
        end else if (sz > 0) begin
          w = fq.pop_front();
          popped = 1;
          if (m_mode) for (int i = 0; i < 4; i++) pq.push_back({m_bank, 4'(w >> (12 - 4 * i))});
          else        for (int i = 0; i < 2; i++) pq.push_back(8'(w >> (8 - 8 * i)));
          m_pal = pq.pop_front();
        end else begin
          m_pal  = border;
          uf_set = 1;
        end
      end else if (pix_ce) begin
        m_pal = border;
      end
      if (word_valid && (sz < int'(DEPTH) || popped)) fq.push_back(word_data);
      if (pix_ce && m_actp && !active) m_fe = 1'b0;
    end
    if (pix_ce) m_actp = active;
    if (uf_set) m_uf = 1'b1;
    else if (underflow_clr) m_uf = 1'b0;
    m_req = m_fe && (fq.size() < int'(DEPTH));
  endtask

  // Drive inputs away from the edge, advance one clock, compare all outputs.
  task automatic step(input logic ls, input logic pce, input logic act, input logic md,
                      input logic [3:0] bk, input logic [7:0] brd,
                      input logic wv, input logic [15:0] wd, input logic clr);
    line_start = ls; pix_ce = pce; active = act; mode = md; pal_bank = bk;
    border = brd; word_valid = wv; word_data = wd; underflow_clr = clr;
    @(posedge clk);
    model_update();
    #1;
    chk8("pal_addr", pal_addr, m_pal);
    chk1("underflow", underflow, m_uf);
    chk1("word_req", word_req, m_req);
  endtask

  task automatic rand_step();
    logic wv;
    if ($urandom_range(0, 19) == 0) r_act = ~r_act;
    wv = (word_req && $urandom_range(0, 9) < 7) || ($urandom_range(0, 49) == 0);
    step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, r_act,
         $urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom),
         wv, 16'($urandom), $urandom_range(0, 19) == 0);
  endtask

  initial begin
    reset_n = 1'b0;
    pix_ce = 0; line_start = 0; active = 0; mode = 0; pal_bank = 0;
    border = 0; word_valid = 0; word_data = 0; underflow_clr = 0;
    r_act = 1'b0;
    model_reset();
    #3;
    chk8("reset_pal", pal_addr, 8'h00);
    chk1("reset_req", word_req, 1'b0);
    chk1("reset_uf", underflow, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 8bpp line: one word, two pixels, then fill the FIFO.
    step(1, 0, 0, 0, 4'h0, 8'h00, 0, 16'h0000, 0);
    step(0, 0, 0, 0, 4'h0, 8'h00, 1, 16'hA1B2, 0);
    step(0, 1, 1, 0, 4'h0, 8'h00, 0, 16'h0000, 0);
    chk8("8bpp_p0", pal_addr, 8'hA1);
    step(0, 1, 1, 0, 4'h0, 8'h00, 0, 16'h0000, 0);
    chk8("8bpp_p1", pal_addr, 8'hB2);
    step(0, 0, 1, 0, 4'h0, 8'h00, 1, 16'h1111, 0);
    step(0, 0, 1, 0, 4'h0, 8'h00, 1, 16'h2222, 0);
    step(0, 0, 1, 0, 4'h0, 8'h00, 1, 16'h3333, 0);
    chk1("req_before_full", word_req, 1'b1);
    step(0, 0, 1, 0, 4'h0, 8'h00, 1, 16'h4444, 0);
    chk1("req_full", word_req, 1'b0);

    // Push and pop while full, then drain.
    step(0, 1, 1, 0, 4'h0, 8'h00, 1, 16'hBEEF, 0);
    chk8("full_pushpop_pix", pal_addr, 8'h11);
    chk1("full_pushpop_req", word_req, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 4'h0, 8'hEE, 0, 16'h0000, 0);

    // 4bpp line with bank 3; bank input changes mid-line.
    step(1, 0, 0, 1, 4'h3, 8'h00, 0, 16'h0000, 1);
    step(0, 0, 0, 1, 4'h7, 8'h00, 1, 16'h1234, 0);
    step(0, 1, 1, 1, 4'h7, 8'h00, 0, 16'h0000, 0);
    chk8("4bpp_p0", pal_addr, 8'h31);
    step(0, 1, 1, 1, 4'h7, 8'h00, 1, 16'h5678, 0);
    chk8("4bpp_p1", pal_addr, 8'h32);
    step(0, 1, 1, 1, 4'h7, 8'h00, 0, 16'h0000, 0);
    chk8("4bpp_p2", pal_addr, 8'h33);
    step(0, 1, 1, 1, 4'h7, 8'h00, 0, 16'h0000, 0);
    chk8("4bpp_p3", pal_addr, 8'h34);
    step(0, 1, 1, 1, 4'h7, 8'h00, 0, 16'h0000, 0);
    chk8("4bpp_bank_held", pal_addr, 8'h35);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 4'h7, 8'h00, 0, 16'h0000, 0);

    // Starvation, resume, clear.
    step(0, 1, 1, 1, 4'h7, 8'h0F, 0, 16'h0000, 0);
    chk8("starve_border", pal_addr, 8'h0F);
    chk1("starve_uf", underflow, 1'b1);
    step(0, 0, 1, 1, 4'h7, 8'h0F, 1, 16'h9ABC, 0);
    step(0, 1, 1, 1, 4'h7, 8'h0F, 0, 16'h0000, 0);
    chk8("resume_pix", pal_addr, 8'h39);
    step(0, 0, 1, 1, 4'h7, 8'h0F, 0, 16'h0000, 1);
    chk1("uf_cleared", underflow, 1'b0);

    // line_start mid-line discards queued words.
    step(1, 0, 1, 0, 4'h0, 8'h55, 0, 16'h0000, 0);
    step(0, 0, 1, 0, 4'h0, 8'h55, 1, 16'hC0C1, 0);
    step(0, 0, 1, 0, 4'h0, 8'h55, 1, 16'hC2C3, 0);
    step(1, 1, 1, 0, 4'h0, 8'h55, 0, 16'h0000, 0);
    chk8("ls_border", pal_addr, 8'h55);
    step(0, 1, 1, 0, 4'h0, 8'h55, 0, 16'h0000, 0);
    chk8("ls_no_old_word", pal_addr, 8'h55);
    chk1("ls_uf", underflow, 1'b1);

    // Randomized traffic.
    r_act = 1'b1;
    for (int i = 0; i < 1500; i++) rand_step();

    // Asynchronous reset mid-line.
    step(1, 0, 1, 0, 4'h0, 8'h00, 0, 16'h0000, 0);
    step(0, 0, 1, 0, 4'h0, 8'h00, 1, 16'hFEDC, 0);
    step(0, 1, 1, 0, 4'h0, 8'h00, 0, 16'h0000, 0);
    chk8("pre_reset_pix", pal_addr, 8'hFE);
    #2;
    reset_n = 1'b0;
    #1;
    chk8("async_rst_pal", pal_addr, 8'h00);
    chk1("async_rst_req", word_req, 1'b0);
    chk1("async_rst_uf", underflow, 1'b0);
    model_reset();
    pix_ce = 0; line_start = 0; word_valid = 0; underflow_clr = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) rand_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
